// File: rtl/smart_home_climate_if.sv
// Zone-controller bundle: global enable/mode and packed samples in, per-zone drives and faults out.
interface smart_home_climate_if #(
  parameter int unsigned ZONES = 4,
  parameter int unsigned TW    = 5
);
  logic                  en;
  logic [1:0]            mode;
  logic [ZONES*TW-1:0]   temperature;
  logic [ZONES-1:0]      heating;
  logic [ZONES-1:0]      cooling;
  logic [ZONES-1:0]      fault;

  modport master (output en, mode, temperature, input heating, cooling, fault);
  modport slave  (input en, mode, temperature, output heating, cooling, fault);
endinterface

// File: rtl/smart_home_climate.sv
// Multi-zone hysteresis heat/cool controller with per-zone dwell counter and sensor-fault override.
// The dwell counter reloads only when a zone actually changes state.
module smart_home_climate #(
  parameter int unsigned ZONES     = 4,
  parameter int unsigned TW        = 5,
  parameter int unsigned HEAT_ON   = 18,
  parameter int unsigned HEAT_OFF  = 20,
  parameter int unsigned COOL_ON   = 22,
  parameter int unsigned COOL_OFF  = 20,
  parameter int unsigned MIN_DWELL = 4
) (
  input logic                  clk,
  input logic                  rst,
  smart_home_climate_if.slave  bus
);

  localparam int unsigned CW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [CW-1:0] DwellLoad = CW'(MIN_DWELL - 1);
  localparam logic [TW-1:0] HeatOn  = TW'(HEAT_ON);
  localparam logic [TW-1:0] HeatOff = TW'(HEAT_OFF);
  localparam logic [TW-1:0] CoolOn  = TW'(COOL_ON);
  localparam logic [TW-1:0] CoolOff = TW'(COOL_OFF);

  localparam logic [1:0] ModeOff  = 2'b00;
  localparam logic [1:0] ModeAuto = 2'b01;
  localparam logic [1:0] ModeHeat = 2'b10;
  localparam logic [1:0] ModeCool = 2'b11;

  typedef enum logic [1:0] {StIdle, StHeat, StCool} state_e;

  logic run;
  logic heat_ok;
  logic cool_ok;
  logic heat_only;
  logic cool_only;

  assign run       = bus.en && (bus.mode != ModeOff);
  assign heat_only = (bus.mode == ModeHeat);
  assign cool_only = (bus.mode == ModeCool);
  assign heat_ok   = (bus.mode == ModeAuto) || heat_only;
  assign cool_ok   = (bus.mode == ModeAuto) || cool_only;

  logic [ZONES-1:0] heat_all;
  logic [ZONES-1:0] cool_all;
  logic [ZONES-1:0] fault_all;

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    logic [TW-1:0] temp;
    logic          bad;
    logic          forced;
    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          heat_q, cool_q, fault_q;

    assign temp = bus.temperature[z*TW +: TW];
    assign bad  = (temp == '1);
    // Any forcing cause wins over dwell; they all land in IDLE.
    assign forced = bad || !run || (st_q == StHeat && cool_only) || (st_q == StCool && heat_only);

    always_comb begin
      st_d = st_q;
      if (forced) begin
        st_d = StIdle;
      end else if (cnt_q == '0) begin
        unique case (st_q)
          StIdle: begin
            if (temp <= HeatOn && heat_ok)      st_d = StHeat;
            else if (temp >= CoolOn && cool_ok) st_d = StCool;
          end
          StHeat:  if (temp >= HeatOff) st_d = StIdle;
          StCool:  if (temp <= CoolOff) st_d = StIdle;
          default: st_d = StIdle;
        endcase
      end
      if (st_d != st_q)      cnt_d = DwellLoad;
      else if (cnt_q == '0)  cnt_d = '0;
      else                   cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q    <= StIdle;
        cnt_q   <= '0;
        heat_q  <= 1'b0;
        cool_q  <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        heat_q  <= (st_d == StHeat);
        cool_q  <= (st_d == StCool);
        fault_q <= bad;
      end
    end

    assign heat_all[z]  = heat_q;
    assign cool_all[z]  = cool_q;
    assign fault_all[z] = fault_q;
  end

  assign bus.heating = heat_all;
  assign bus.cooling = cool_all;
  assign bus.fault   = fault_all;

endmodule

// File: tb/tb_smart_home_climate.sv
// Bench for smart_home_climate: directed scenarios with literal expectations, then random
// stimulus, all cycles checked against a behavioural zone model.
module tb_smart_home_climate;

  localparam int ZONES     = 4;
  localparam int TW        = 5;
  localparam int HEAT_ON   = 18;
  localparam int HEAT_OFF  = 20;
  localparam int COOL_ON   = 22;
  localparam int COOL_OFF  = 20;
  localparam int MIN_DWELL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smart_home_climate_if #(.ZONES(ZONES), .TW(TW)) ifc ();

  smart_home_climate #(
    .ZONES(ZONES), .TW(TW), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF),
    .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF), .MIN_DWELL(MIN_DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: state 0 idle, 1 heat, 2 cool; age = edges since entering the current state.
  int   m_st  [ZONES];
  int   m_age [ZONES];
  logic [ZONES-1:0] m_fault;
  bit   model_ok = 0;
  int   tv [ZONES];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  t;
    int  ns;
    bit  bad;
    bit  forced;
    for (int z = 0; z < ZONES; z++) begin
      t = int'(ifc.temperature[z*TW +: TW]);
      if (rst) begin
        m_st[z]    = 0;
        m_age[z]   = MIN_DWELL;
        m_fault[z] = 1'b0;
      end else begin
        bad    = (t == (1 << TW) - 1);
        forced = bad || !ifc.en || ifc.mode == 2'd0 ||
                 (m_st[z] == 1 && ifc.mode == 2'd3) || (m_st[z] == 2 && ifc.mode == 2'd2);
        ns = m_st[z];
        if (forced) ns = 0;
        else if (m_age[z] >= MIN_DWELL - 1) begin
          if (m_st[z] == 0) begin
            if (t <= HEAT_ON && (ifc.mode == 2'd1 || ifc.mode == 2'd2))      ns = 1;
            else if (t >= COOL_ON && (ifc.mode == 2'd1 || ifc.mode == 2'd3)) ns = 2;
          end else if (m_st[z] == 1 && t >= HEAT_OFF) ns = 0;
          else if (m_st[z] == 2 && t <= COOL_OFF)     ns = 0;
        end
        if (ns != m_st[z])      m_age[z] = 0;
        else if (m_age[z] < 1000) m_age[z] = m_age[z] + 1;
        m_st[z]    = ns;
        m_fault[z] = bad;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    if (rst) model_ok = 1;
  end

  initial forever begin
    logic [ZONES-1:0] eh, ec;
    @(negedge clk);
    if (model_ok) begin
      for (int z = 0; z < ZONES; z++) begin
        eh[z] = (m_st[z] == 1);
        ec[z] = (m_st[z] == 2);
      end
      check("model_heating", ifc.heating, eh);
      check("model_cooling", ifc.cooling, ec);
      check("model_fault",   ifc.fault,   m_fault);
    end
  end

  task automatic drive();
    for (int z = 0; z < ZONES; z++) ifc.temperature[z*TW +: TW] = TW'(tv[z]);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit t2_h [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  bit t2_c [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  bit t3_h [8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
  bit t3_c [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  bit t5_c [4]  = '{0, 0, 0, 1};

  initial begin
    int r;
    rst = 1'b1;
    ifc.en = 1'b1;
    ifc.mode = 2'd1;
    for (int z = 0; z < ZONES; z++) tv[z] = 15;
    drive();

    // Reset, then immediate heating on all zones.
    step(2);
    check("rst_heating", ifc.heating, 4'b0000);
    check("rst_cooling", ifc.cooling, 4'b0000);
    check("rst_fault",   ifc.fault,   4'b0000);
    rst = 1'b0;
    step(1);
    check("first_heat", ifc.heating, 4'b1111);

    // Zone 0 ramp 16..25.
    for (int i = 0; i < 10; i++) begin
      tv[0] = 16 + i;
      drive();
      step(1);
      check("ramp_h0", {3'b0, ifc.heating[0]}, {3'b0, t2_h[i]});
      check("ramp_c0", {3'b0, ifc.cooling[0]}, {3'b0, t2_c[i]});
    end

    // Zone 1 dwell hold: heat at 18, jump to 25.
    tv[1] = 20; drive(); step(5);
    tv[1] = 18; drive(); step(1);
    check("dwell_h1_entry", {3'b0, ifc.heating[1]}, 4'b0001);
    tv[1] = 25; drive();
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("dwell_h1", {3'b0, ifc.heating[1]}, {3'b0, t3_h[i]});
      check("dwell_c1", {3'b0, ifc.cooling[1]}, {3'b0, t3_c[i]});
    end

    // Mode override on a freshly heating zone 2.
    tv[2] = 20; drive(); step(5);
    tv[2] = 15; drive(); step(1);
    check("ovr_h2_entry", {3'b0, ifc.heating[2]}, 4'b0001);
    ifc.mode = 2'd3; step(1);
    check("ovr_h2_off", {3'b0, ifc.heating[2]}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ovr_h2_stay", {3'b0, ifc.heating[2]}, 4'b0000);
    end
    ifc.mode = 2'd0; step(1);
    check("off_heating", ifc.heating, 4'b0000);
    check("off_cooling", ifc.cooling, 4'b0000);
    ifc.mode = 2'd1; ifc.en = 1'b0; step(1);
    check("en0_heating", ifc.heating, 4'b0000);
    check("en0_cooling", ifc.cooling, 4'b0000);

    // Sensor fault on cooling zone 3.
    ifc.en = 1'b1; tv[3] = 25; drive(); step(5);
    check("mix_heating", ifc.heating, 4'b0100);
    check("mix_cooling", ifc.cooling, 4'b1011);
    tv[3] = 31; drive(); step(1);
    check("flt_fault",   ifc.fault,   4'b1000);
    check("flt_cooling", ifc.cooling, 4'b0011);
    check("flt_heating", ifc.heating, 4'b0100);
    tv[3] = 25; drive();
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("flt_clear", {3'b0, ifc.fault[3]}, 4'b0000);
      check("flt_c3", {3'b0, ifc.cooling[3]}, {3'b0, t5_c[i]});
    end

    // Reset mid-operation.
    rst = 1'b1; step(1);
    check("mid_rst_heating", ifc.heating, 4'b0000);
    check("mid_rst_cooling", ifc.cooling, 4'b0000);
    rst = 1'b0; step(1);
    check("post_rst_heating", ifc.heating, 4'b0100);
    check("post_rst_cooling", ifc.cooling, 4'b1011);

    // Random phase.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) ifc.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) ifc.en = ~ifc.en;
      for (int z = 0; z < ZONES; z++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3)        tv[z] = 31;
        else if (r < 20)  tv[z] = 14 + int'($urandom_range(0, 12));
        else if (r < 50) begin
          if (tv[z] == 31) tv[z] = 20;
          else tv[z] = tv[z] + (($urandom_range(0, 1) == 1) ? 1 : -1);
          if (tv[z] < 10) tv[z] = 10;
          if (tv[z] > 28) tv[z] = 28;
        end
      end
      drive();
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smart_home_climate.md
Name: smart_home_climate

Overview:
Parametrised multi-zone heating/cooling controller for the smart-home design. It generalises the single-zone two-threshold AC to ZONES independent zones. Each zone has configurable hysteresis thresholds, a minimum-dwell counter against relay chatter, a global operating mode and sensor-fault detection. It sits beside the LED and blinds controllers and takes per-zone temperature samples from the sensor front end.

Parameters:
ZONES, 4, number of independent zones
TW, 5, temperature sample width in bits (unsigned, 1 °C per LSB)
HEAT_ON, 18, zone enters HEAT when temp <= HEAT_ON
HEAT_OFF, 20, zone leaves HEAT when temp >= HEAT_OFF
COOL_ON, 22, zone enters COOL when temp >= COOL_ON
COOL_OFF, 20, zone leaves COOL when temp <= COOL_OFF
MIN_DWELL, 4, minimum cycles a zone stays in any state before a normal transition (>= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global enable; 0 behaves exactly as mode OFF
mode  in  2  00 OFF, 01 AUTO, 10 HEAT_ONLY, 11 COOL_ONLY
temperature  in  ZONES*TW  packed samples; zone z at bits [z*TW +: TW]
heating  out  ZONES  per-zone heater drive, registered
cooling  out  ZONES  per-zone cooler drive, registered
fault  out  ZONES  per-zone sensor fault, registered

Behaviour:
- Required parameter relation: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON < 2^TW-1. The design need not handle other settings.
- Reset: every zone in IDLE with dwell counter 0. heating, cooling and fault are all 0 one edge after rst is sampled high. Reset mid-operation aborts any state, including HEAT or COOL, on that edge.
- Per-zone FSM with states IDLE, HEAT and COOL. Outputs are decoded from registered state: heating[z] = (HEAT), cooling[z] = (COOL). They are never both 1.
- Latency: a sample present at edge k produces its state change, and the new output, immediately after edge k. This is 1-cycle latency.
- Dwell counter, width clog2(MIN_DWELL), one per zone:
  - loads MIN_DWELL-1 on every state entry, including forced entries;
  - otherwise decrements and saturates at 0.
- A normal transition is allowed only on an edge where the counter is 0. With the default, a state entered at edge k can exit no earlier than edge k+4.
- Normal transitions, enabled only when counter is 0:
  - IDLE->HEAT: temp <= HEAT_ON and mode is AUTO or HEAT_ONLY.
  - IDLE->COOL: temp >= COOL_ON and mode is AUTO or COOL_ONLY.
  - HEAT->IDLE: temp >= HEAT_OFF.
  - COOL->IDLE: temp <= COOL_OFF.
  - HEAT<->COOL directly: never. The zone always passes through IDLE and serves a full dwell there.
- Forced transitions to IDLE ignore the dwell counter and take effect on the same edge. Causes, in priority order:
  1. fault condition;
  2. en = 0 or mode OFF;
  3. HEAT while mode is COOL_ONLY;
  4. COOL while mode is HEAT_ONLY.
  A forced transition loads the counter.
- Fault:
  - temp == all-ones (2^TW-1, disconnected sensor) sets fault[z] = 1 on the next edge and forces IDLE;
  - fault[z] follows the sample each cycle and clears on the first edge with a valid sample;
  - the zone then obeys dwell from its forced IDLE entry.
- Zones are fully independent. Only en, mode and rst are shared.
- Boundary values: temp exactly HEAT_ON starts heating, and temp exactly HEAT_OFF stops it. The COOL thresholds behave the same way. Temps strictly between the ON/OFF pair hold the current state.

Test Plan:
1. Reset with all zones sampled at 15 and rst held high for 2 cycles -> heating = cooling = fault = 0. On the first edge after rst drops (mode AUTO, en = 1), heating = 4'b1111.
2. Hysteresis and dwell on zone 0 (AUTO):
   - zone 0 ramps 15->25, one step per cycle; HEAT holds until the sample reaches 20, then drops to IDLE;
   - COOL asserts only once temp >= 22 and at least 4 cycles after IDLE entry;
   - temps 21 and 20 between the states keep both outputs 0.
3. Dwell hold: zone 1 enters HEAT at 18, then its temp jumps to 25 on the next cycle -> heating stays 1 for 4 cycles total. The zone then goes IDLE for 4 cycles, then cooling = 1. There is never a direct HEAT->COOL step.
4. Mode override:
   - zone 2 heating, mode switched to COOL_ONLY -> heating[2] = 0 on the next edge despite dwell, and it is never re-asserted while temp is 15;
   - mode OFF or en = 0 -> all outputs 0 on the next edge.
5. Sensor fault: zone 3 is in COOL and its sample becomes 31 -> fault[3] = 1 and cooling[3] = 0 on the next edge. Other zones are unaffected. When the sample returns to 25, fault[3] = 0 on the next edge and cooling[3] re-asserts 4 cycles after the forced IDLE entry.
6. Reset mid-operation: with zones in mixed HEAT/COOL, pulse rst for 1 cycle -> all outputs 0 on the next edge. Transitions are then immediate, since the counters are 0.
